// File: rtl/sum_mean_div.sv
// sum_mean_div
//   Turns a finished window sum into a window mean (sum / pixel count) for the
//   mean/box-filter path. The divider is an iterative restoring one that
//   produces one quotient bit per clock. The dividend and divisor are captured
//   on an accepted start, so the upstream sum register can be reloaded while
//   a division runs. The quotient can be rounded half up, and it saturates to
//   the pixel width. A zero divisor is flagged.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   division request, sampled only while idle
//   sum_in    in   dividend, captured on an accepted start
//   count_in  in   divisor (window pixel count), captured on an accepted start
//   busy      out  high from the cycle after an accepted start through the done cycle
//   done      out  one-cycle pulse; result outputs are valid from this cycle
//   mean_out  out  rounded or truncated quotient, saturated to WIDTH_Q bits
//   rem_out   out  unrounded remainder (sum mod count)
//   sat       out  quotient exceeded 2^WIDTH_Q-1 and was clamped
//   div_zero  out  divisor was zero for this result
module sum_mean_div #(
  parameter int WIDTH_SUM = 13,
  parameter int WIDTH_CNT = 5,
  parameter int WIDTH_Q   = 8,
  parameter int ROUND     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH_SUM-1:0] sum_in,
  input  logic [WIDTH_CNT-1:0] count_in,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH_Q-1:0]   mean_out,
  output logic [WIDTH_CNT-1:0] rem_out,
  output logic                 sat,
  output logic                 div_zero
);

  localparam int CNT_W = (WIDTH_SUM > 1) ? $clog2(WIDTH_SUM) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH_SUM-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH_CNT-1:0] dvs_q, dvs_d;
  logic [WIDTH_CNT:0]   rem_q, rem_d;     // one spare bit holds the shifted partial remainder
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH_Q-1:0]   mean_q, mean_d;
  logic [WIDTH_CNT-1:0] remo_q, remo_d;
  logic                 sat_q, sat_d;
  logic                 dz_q, dz_d;

  logic [WIDTH_CNT:0]   rem_t;
  logic [WIDTH_SUM:0]   q_rnd;

  // Round half up. Doubling the remainder fits in WIDTH_CNT+1 bits because
  // the remainder is always smaller than the divisor. The extra quotient bit
  // absorbs the carry from the increment.
  function automatic logic [WIDTH_SUM:0] round_quot(
    input logic [WIDTH_SUM-1:0] q,
    input logic [WIDTH_CNT:0]   r,
    input logic [WIDTH_CNT-1:0] d
  );
    logic [WIDTH_CNT:0] r2;
    r2 = {r[WIDTH_CNT-1:0], 1'b0};
    if ((ROUND != 0) && (r2 >= {1'b0, d}))
      return {1'b0, q} + (WIDTH_SUM+1)'(1);
    else
      return {1'b0, q};
  endfunction

  function automatic logic is_over(input logic [WIDTH_SUM:0] q);
    return |q[WIDTH_SUM:WIDTH_Q];
  endfunction

  function automatic logic [WIDTH_Q-1:0] sat_val(input logic [WIDTH_SUM:0] q);
    return is_over(q) ? {WIDTH_Q{1'b1}} : q[WIDTH_Q-1:0];
  endfunction

  assign rem_t = {rem_q[WIDTH_CNT-1:0], dvd_q[WIDTH_SUM-1]};
  assign q_rnd = round_quot(dvd_q, rem_q, dvs_q);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mean_d  = mean_q;
    remo_d  = remo_q;
    sat_d   = sat_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          dvd_d   = sum_in;
          dvs_d   = count_in;
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH_SUM - 1);
          busy_d  = 1'b1;
          state_d = (count_in == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        busy_d = 1'b1;
        if (rem_t >= {1'b0, dvs_q}) begin
          rem_d = rem_t - {1'b0, dvs_q};
          dvd_d = {dvd_q[WIDTH_SUM-2:0], 1'b1};
        end else begin
          rem_d = rem_t;
          dvd_d = {dvd_q[WIDTH_SUM-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIN: begin
        // busy stays high so it covers the done cycle that follows this edge
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
        if (dvs_q == '0) begin
          mean_d = {WIDTH_Q{1'b1}};
          remo_d = '0;
          sat_d  = 1'b0;
          dz_d   = 1'b1;
        end else begin
          mean_d = sat_val(q_rnd);
          remo_d = rem_q[WIDTH_CNT-1:0];
          sat_d  = is_over(q_rnd);
          dz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mean_q  <= '0;
      remo_q  <= '0;
      sat_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mean_q  <= mean_d;
      remo_q  <= remo_d;
      sat_q   <= sat_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mean_out = mean_q;
  assign rem_out  = remo_q;
  assign sat      = sat_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_sum_mean_div.sv
module tb_sum_mean_div;
  localparam int WS = 13;
  localparam int WC = 5;
  localparam int WQ = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [WS-1:0] sum_in;
  logic [WC-1:0] count_in;
  logic          busy, done, sat, div_zero;
  logic [WQ-1:0] mean_out;
  logic [WC-1:0] rem_out;
  logic          t_busy, t_done, t_sat, t_dz;
  logic [WQ-1:0] t_mean;
  logic [WC-1:0] t_rem;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int mean; int rem; bit sat; bit dz; int lat; int tmean;
  } exp_t;

  typedef struct {
    int mean; int rem; bit sat; bit dz; int lat; int bcyc; bit busy_done; bit to; int tmean;
  } obs_t;

  exp_t sb[$];

  sum_mean_div #(.WIDTH_SUM(WS), .WIDTH_CNT(WC), .WIDTH_Q(WQ), .ROUND(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sum_in(sum_in), .count_in(count_in),
    .busy(busy), .done(done), .mean_out(mean_out), .rem_out(rem_out),
    .sat(sat), .div_zero(div_zero)
  );

  sum_mean_div #(.WIDTH_SUM(WS), .WIDTH_CNT(WC), .WIDTH_Q(WQ), .ROUND(0)) u_trunc (
    .clk(clk), .rst_n(rst_n), .start(start), .sum_in(sum_in), .count_in(count_in),
    .busy(t_busy), .done(t_done), .mean_out(t_mean), .rem_out(t_rem),
    .sat(t_sat), .div_zero(t_dz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int s, input int c);
    exp_t e;
    int q;
    if (c == 0) begin
      e.mean = 255; e.rem = 0; e.sat = 1'b0; e.dz = 1'b1; e.lat = 1; e.tmean = 255;
    end else begin
      q       = s / c;
      e.tmean = (q > 255) ? 255 : q;
      e.rem   = s % c;
      if (2 * e.rem >= c) q = q + 1;
      e.sat   = (q > 255);
      e.mean  = e.sat ? 255 : q;
      e.dz    = 1'b0;
      e.lat   = WS + 1;
    end
    return e;
  endfunction

  // Drives one start pulse, records the expectation and waits (bounded) for done.
  task automatic run_op(input int s, input int c, output obs_t o);
    int edges;
    @(negedge clk);
    start = 1'b1; sum_in = WS'(s); count_in = WC'(c);
    sb.push_back(model(s, c));
    @(negedge clk);
    start = 1'b0;
    edges = 0; o.bcyc = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) o.bcyc++;
      @(negedge clk);
      edges++;
    end
    o.to = (done !== 1'b1);
    o.lat = edges;
    o.busy_done = busy;
    o.mean = int'(mean_out); o.rem = int'(rem_out);
    o.sat = sat; o.dz = div_zero; o.tmean = int'(t_mean);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; sum_in = '0; count_in = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sat, div_zero} !== 4'b0000 || mean_out !== '0 || rem_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b done=%0b mean=%0d rem=%0d sat=%0b dz=%0b exp all 0",
               busy, done, mean_out, rem_out, sat, div_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_activity got busy=%0b done=%0b exp 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    obs_t o; exp_t e;
    run_op(2295, 9, o);
    e = sb.pop_front();
    checks++; if (o.to)        begin failures++; $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (o.lat != e.lat) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", o.lat, e.lat); end
    checks++; if (o.bcyc != 14)   begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=14", o.bcyc); end
    checks++; if (o.busy_done !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%0b exp=1", o.busy_done); end
    checks++; if (o.mean != e.mean) begin failures++; $display("FAIL basic_mean got=%0d exp=%0d", o.mean, e.mean); end
    checks++; if (o.rem != e.rem)   begin failures++; $display("FAIL basic_rem got=%0d exp=%0d", o.rem, e.rem); end
    checks++; if (o.sat !== e.sat || o.dz !== e.dz) begin
      failures++; $display("FAIL basic_flags got sat=%0b dz=%0b exp sat=%0b dz=%0b", o.sat, o.dz, e.sat, e.dz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || int'(mean_out) != e.mean) begin
      failures++;
      $display("FAIL basic_pulse_hold got done=%0b busy=%0b mean=%0d exp 0 0 %0d", done, busy, mean_out, e.mean);
    end
  endtask

  task automatic test_round();
    int sums[2] = '{1004, 1000};
    obs_t o; exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(sums[i], 9, o);
      e = sb.pop_front();
      checks++; if (o.to || o.mean != e.mean) begin
        failures++; $display("FAIL round_mean[%0d] got=%0d exp=%0d timeout=%0b", i, o.mean, e.mean, o.to);
      end
      checks++; if (o.rem != e.rem) begin
        failures++; $display("FAIL round_rem[%0d] got=%0d exp=%0d", i, o.rem, e.rem);
      end
      checks++; if (o.tmean != e.tmean) begin
        failures++; $display("FAIL trunc_mean[%0d] got=%0d exp=%0d", i, o.tmean, e.tmean);
      end
    end
  endtask

  task automatic test_saturation();
    int sums[2] = '{8191, 90};
    obs_t o; exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(sums[i], 9, o);
      e = sb.pop_front();
      checks++; if (o.to || o.mean != e.mean) begin
        failures++; $display("FAIL sat_mean[%0d] got=%0d exp=%0d timeout=%0b", i, o.mean, e.mean, o.to);
      end
      checks++; if (o.sat !== e.sat) begin
        failures++; $display("FAIL sat_flag[%0d] got=%0b exp=%0b", i, o.sat, e.sat);
      end
      checks++; if (o.rem != e.rem) begin
        failures++; $display("FAIL sat_rem[%0d] got=%0d exp=%0d", i, o.rem, e.rem);
      end
    end
  endtask

  task automatic test_div_zero();
    int sums[2] = '{500, 25};
    int cnts[2] = '{0, 5};
    obs_t o; exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(sums[i], cnts[i], o);
      e = sb.pop_front();
      checks++; if (o.to || o.lat != e.lat) begin
        failures++; $display("FAIL dz_latency[%0d] got=%0d exp=%0d timeout=%0b", i, o.lat, e.lat, o.to);
      end
      checks++; if (o.mean != e.mean || o.rem != e.rem) begin
        failures++; $display("FAIL dz_result[%0d] got mean=%0d rem=%0d exp mean=%0d rem=%0d", i, o.mean, o.rem, e.mean, e.rem);
      end
      checks++; if (o.dz !== e.dz || o.sat !== e.sat) begin
        failures++; $display("FAIL dz_flags[%0d] got dz=%0b sat=%0b exp dz=%0b sat=%0b", i, o.dz, o.sat, e.dz, e.sat);
      end
    end
  endtask

  task automatic test_ignore_restart();
    exp_t e;
    int   ndone;
    int   got_mean;
    obs_t o;
    @(negedge clk);
    start = 1'b1; sum_in = WS'(50); count_in = WC'(5);
    sb.push_back(model(50, 5));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; sum_in = WS'(7000); count_in = WC'(25);
    @(negedge clk);
    start = 1'b0;
    ndone = 0; got_mean = -1;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin ndone++; got_mean = int'(mean_out); end
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++; if (ndone != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", ndone); end
    checks++; if (got_mean != e.mean) begin failures++; $display("FAIL restart_mean got=%0d exp=%0d", got_mean, e.mean); end
    run_op(7000, 25, o);
    e = sb.pop_front();
    checks++; if (o.to || o.mean != e.mean || o.sat !== e.sat) begin
      failures++; $display("FAIL idle_7000_25 got mean=%0d sat=%0b exp mean=%0d sat=%0b", o.mean, o.sat, e.mean, e.sat);
    end
  endtask

  task automatic test_back_to_back();
    int sums[4] = '{4321, 777, 6000, 100};
    int cnts[4] = '{25, 9, 31, 7};
    obs_t o; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(sums[i], cnts[i], o);
      e = sb.pop_front();
      checks++; if (o.to || o.lat != e.lat) begin
        failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d timeout=%0b", i, o.lat, e.lat, o.to);
      end
      checks++; if (o.mean != e.mean || o.rem != e.rem || o.sat !== e.sat) begin
        failures++; $display("FAIL b2b_result[%0d] got mean=%0d rem=%0d sat=%0b exp mean=%0d rem=%0d sat=%0b",
                             i, o.mean, o.rem, o.sat, e.mean, e.rem, e.sat);
      end
    end
  endtask

  task automatic test_async_reset();
    int   ndone;
    obs_t o; exp_t e;
    @(negedge clk);
    start = 1'b1; sum_in = WS'(1000); count_in = WC'(9);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sat, div_zero} !== 4'b0000 || mean_out !== '0 || rem_out !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%0b done=%0b mean=%0d rem=%0d sat=%0b dz=%0b exp all 0",
               busy, done, mean_out, rem_out, sat, div_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", ndone); end
    run_op(25, 25, o);
    e = sb.pop_front();
    checks++; if (o.to || o.mean != e.mean || o.rem != e.rem) begin
      failures++; $display("FAIL post_reset got mean=%0d rem=%0d exp mean=%0d rem=%0d", o.mean, o.rem, e.mean, e.rem);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturation();
    test_div_zero();
    test_ignore_restart();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
